conv_buf_seq: RTL and testbench

- Sequencer for the 4-row x 16-column byte line buffer in the CNN datapath.
- Fetches 4-byte input words through a valid/ready handshake and drives the buffer's shift, one-hot column-write-enable and read-index inputs.
- Sweeps a 4x4 window across each buffered 4-row band, then rolls the band down one image row, until the whole image has been visited.
- Sits between the input feature-map reader and the line buffer; window consumers see win_valid aligned with the buffer's registered window output.

---
 rtl/conv_buf_pkg.sv | 26 ++
 rtl/conv_buf_seq_win_idx_gen.sv | 41 ++++
 rtl/conv_buf_seq.sv | 183 ++++++++++++++++++
 tb/tb_conv_buf_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_buf_pkg.sv
// Shared types and geometry for the CNN line-buffer sequencer.
// Used by conv_buf_seq and win_idx_gen.
package conv_buf_pkg;

    localparam int BUF_ROWS   = 4;
    localparam int BUF_COLS   = 16;
    localparam int WORD_BYTES = 4;
    localparam int WIN        = 4;
    localparam int MAX_IDX    = BUF_COLS - WIN;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        READ,
        DRAIN
    } state_e;

    // Word w lands in columns 4w..4w+3; bit (15-c) selects column c.
    function automatic logic [BUF_COLS-1:0] col_en(input logic [1:0] word);
        logic [BUF_COLS-1:0] msb;
        msb = {1'b1, {(BUF_COLS-1){1'b0}}};
        return msb >> (WORD_BYTES * int'(word));
    endfunction

endpackage

// File: rtl/conv_buf_seq_win_idx_gen.sv
// Window column index counter: steps by STRIDE up to MAX_IDX,
// holds while the consumer stalls, wraps to 0 after the last index.
module win_idx_gen
    import conv_buf_pkg::*;
#(
    parameter int STRIDE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       hold_i,
    output logic       issue_o,
    output logic [3:0] idx_o,
    output logic       last_o
);

    logic [3:0] idx_q, idx_d;

    assign issue_o = en_i && !hold_i;
    assign last_o  = (idx_q == 4'(MAX_IDX));
    assign idx_o   = idx_q;

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (issue_o) begin
            idx_d = last_o ? 4'd0 : idx_q + 4'(STRIDE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/conv_buf_seq.sv
// Line-buffer sequencer: fills 4-row bands, sweeps 4x4 windows, rolls rows.
// Optional stall counters under `define CONV_BUF_SEQ_PERF_EN.
module conv_buf_seq
    import conv_buf_pkg::*;
#(
    parameter int IMG_ROWS = 16,
    parameter int STRIDE   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        buf_shift,
    output logic [15:0] buf_en,
    output logic [3:0]  buf_read_idx,
    output logic        win_valid,
    input  logic        out_ready,
    output logic        win_last_col,
    output logic        win_last_row,
    output logic        busy
`ifdef CONV_BUF_SEQ_PERF_EN
    ,
    output logic [15:0] stall_in_cnt,
    output logic [15:0] stall_out_cnt
`endif
);

    state_e     state_q, state_d;
    logic [1:0] word_q, word_d;
    logic [7:0] rows_q, rows_d;
    logic       vld_q, vld_d;
    logic       lcol_q, lcol_d;
    logic       lrow_q, lrow_d;
    logic [3:0] shown_q, shown_d;

    logic       go, xfer, word_done, stall, fin;
    logic       issue, idx_last;
    logic [3:0] idx;

    assign go        = (state_q == IDLE) && start;
    assign xfer      = in_valid && in_ready;
    assign word_done = xfer && (word_q == 2'd3);
    assign stall     = vld_q && !out_ready;
    assign fin       = vld_q && out_ready && lcol_q;

    win_idx_gen #(
        .STRIDE (STRIDE)
    ) u_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (go),
        .en_i    (state_q == READ),
        .hold_i  (stall),
        .issue_o (issue),
        .idx_o   (idx),
        .last_o  (idx_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = LOAD;
            LOAD: begin
                if (word_done) begin
                    state_d = (rows_q < 8'(BUF_ROWS - 1)) ? SHIFT : READ;
                end
            end
            SHIFT: state_d = LOAD;
            READ:  if (issue && idx_last) state_d = DRAIN;
            DRAIN: if (fin) state_d = lrow_q ? IDLE : SHIFT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        buf_shift = 1'b0;
        buf_en    = '0;
        busy      = (state_q != IDLE);
        unique case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) buf_en = col_en(word_q);
            end
            SHIFT:   buf_shift = 1'b1;
            default: ;
        endcase
    end

    // A stalled window keeps its index so the buffer re-outputs it.
    always_comb begin
        word_d  = word_q;
        rows_d  = rows_q;
        vld_d   = vld_q;
        lcol_d  = lcol_q;
        lrow_d  = lrow_q;
        shown_d = shown_q;
        if (go) begin
            word_d = '0;
            rows_d = '0;
        end else if (xfer) begin
            word_d = word_q + 2'd1;
            if (word_done) rows_d = rows_q + 8'd1;
        end
        if (issue) begin
            vld_d   = 1'b1;
            shown_d = idx;
            lcol_d  = idx_last;
            lrow_d  = (rows_q == 8'(IMG_ROWS));
        end else if (!stall) begin
            vld_d  = 1'b0;
            lcol_d = 1'b0;
            lrow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            rows_q  <= '0;
            vld_q   <= 1'b0;
            lcol_q  <= 1'b0;
            lrow_q  <= 1'b0;
            shown_q <= '0;
        end else begin
            word_q  <= word_d;
            rows_q  <= rows_d;
            vld_q   <= vld_d;
            lcol_q  <= lcol_d;
            lrow_q  <= lrow_d;
            shown_q <= shown_d;
        end
    end

    assign buf_read_idx = stall ? shown_q : idx;
    assign win_valid    = vld_q;
    assign win_last_col = lcol_q;
    assign win_last_row = lrow_q;

`ifdef CONV_BUF_SEQ_PERF_EN
    logic [15:0] sin_q, sin_d;
    logic [15:0] sout_q, sout_d;

    always_comb begin
        sin_d  = sin_q;
        sout_d = sout_q;
        if (go) begin
            sin_d  = '0;
            sout_d = '0;
        end else begin
            if (state_q == LOAD && !in_valid && sin_q != 16'hFFFF) begin
                sin_d = sin_q + 16'd1;
            end
            if (stall && sout_q != 16'hFFFF) begin
                sout_d = sout_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sin_q  <= '0;
            sout_q <= '0;
        end else begin
            sin_q  <= sin_d;
            sout_q <= sout_d;
        end
    end

    assign stall_in_cnt  = sin_q;
    assign stall_out_cnt = sout_q;
`endif

endmodule

// File: tb/tb_conv_buf_seq.sv
// Bench for conv_buf_seq: frame table plus reset/stall sequences.
// Two instances: 4 rows stride 1, and 6 rows stride 4.
module tb_conv_buf_seq;

    localparam int R0 = 4;
    localparam int S0 = 1;
    localparam int R1 = 6;
    localparam int S1 = 4;

    typedef struct {
        int idx;
        bit lc;
        bit lr;
    } win_t;

    typedef struct {
        int s;
        int gap;
        int ingaps;
        int stall_idx;
        int stall_len;
        bit mid_start;
        int exp_words;
        int exp_shifts;
        int exp_wins;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  start_v;
    logic [1:0]  in_valid_v;
    logic [1:0]  out_ready_v;
    logic [1:0]  in_ready_v;
    logic [1:0]  buf_shift_v;
    logic [1:0]  win_valid_v;
    logic [1:0]  wlc_v;
    logic [1:0]  wlr_v;
    logic [1:0]  busy_v;
    logic [15:0] buf_en_v [2];
    logic [3:0]  ridx_v [2];
`ifdef CONV_BUF_SEQ_PERF_EN
    logic [15:0] sic_v [2];
    logic [15:0] soc_v [2];
`endif

    int   n_pass = 0;
    int   n_total = 0;
    win_t sb[$];

    always #5 clk = ~clk;

    conv_buf_seq #(
        .IMG_ROWS (R0),
        .STRIDE   (S0)
    ) u_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start_v[0]),
        .in_valid     (in_valid_v[0]),
        .in_ready     (in_ready_v[0]),
        .buf_shift    (buf_shift_v[0]),
        .buf_en       (buf_en_v[0]),
        .buf_read_idx (ridx_v[0]),
        .win_valid    (win_valid_v[0]),
        .out_ready    (out_ready_v[0]),
        .win_last_col (wlc_v[0]),
        .win_last_row (wlr_v[0]),
        .busy         (busy_v[0])
`ifdef CONV_BUF_SEQ_PERF_EN
        ,
        .stall_in_cnt  (sic_v[0]),
        .stall_out_cnt (soc_v[0])
`endif
    );

    conv_buf_seq #(
        .IMG_ROWS (R1),
        .STRIDE   (S1)
    ) u_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start_v[1]),
        .in_valid     (in_valid_v[1]),
        .in_ready     (in_ready_v[1]),
        .buf_shift    (buf_shift_v[1]),
        .buf_en       (buf_en_v[1]),
        .buf_read_idx (ridx_v[1]),
        .win_valid    (win_valid_v[1]),
        .out_ready    (out_ready_v[1]),
        .win_last_col (wlc_v[1]),
        .win_last_row (wlr_v[1]),
        .busy         (busy_v[1])
`ifdef CONV_BUF_SEQ_PERF_EN
        ,
        .stall_in_cnt  (sic_v[1]),
        .stall_out_cnt (soc_v[1])
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                      name, act, act, exp, exp);
    endtask

    task automatic check_reset(input int s);
        check("rst_in_ready",  int'(in_ready_v[s]),  0);
        check("rst_buf_shift", int'(buf_shift_v[s]), 0);
        check("rst_busy",      int'(busy_v[s]),      0);
        check("rst_win_valid", int'(win_valid_v[s]), 0);
        check("rst_last_col",  int'(wlc_v[s]),       0);
        check("rst_last_row",  int'(wlr_v[s]),       0);
        check("rst_buf_en",    int'(buf_en_v[s]),    0);
        check("rst_read_idx",  int'(ridx_v[s]),      0);
`ifdef CONV_BUF_SEQ_PERF_EN
        check("rst_stall_in",  int'(sic_v[s]), 0);
        check("rst_stall_out", int'(soc_v[s]), 0);
`endif
    endtask

    task automatic run_frame(input vec_t v, input int abort_pops);
        int s, rows, st, cyc, words, shifts, pops, spurious, clash;
        int stall_obs, gaps_left, stall_left;
        bit last_gap, tog, prev_stall, ending, iv, orr;
        logic [3:0]  prev_ridx;
        logic [15:0] exp_en;
        win_t e;
        s = v.s;
        rows = (s == 0) ? R0 : R1;
        st = (s == 0) ? S0 : S1;
        cyc = 0; words = 0; shifts = 0; pops = 0;
        spurious = 0; clash = 0; stall_obs = 0;
        gaps_left = v.ingaps; stall_left = v.stall_len;
        last_gap = 0; tog = 1; prev_stall = 0; ending = 0;
        prev_ridx = '0;
        for (int b = 0; b < rows - 3; b++) begin
            for (int i = 0; i <= 12; i += st) begin
                sb.push_back('{i, i == 12, b == rows - 4});
            end
        end
        @(negedge clk);
        start_v[s] = 1'b1;
        in_valid_v[s] = 1'b0;
        out_ready_v[s] = 1'b1;
        @(negedge clk);
        while (!ending && cyc < 3000) begin
            start_v[s] = (v.mid_start && cyc == 40);
            iv = 1'b1;
            if (v.gap == 1) begin
                iv = tog;
                tog = !tog;
            end else if (v.gap == 2) begin
                if (in_ready_v[s] && gaps_left > 0 && !last_gap) begin
                    iv = 1'b0;
                    gaps_left--;
                    last_gap = 1'b1;
                end else begin
                    last_gap = 1'b0;
                end
            end
            orr = 1'b1;
            if (win_valid_v[s] && sb.size() > 0 && stall_left > 0 &&
                sb[0].idx == v.stall_idx) begin
                orr = 1'b0;
                stall_left--;
            end
            in_valid_v[s] = iv;
            out_ready_v[s] = orr;
            #1;
            if (cyc == 0) check("busy_after_start", int'(busy_v[s]), 1);
            if (prev_stall) check("stall_keeps_valid", int'(win_valid_v[s]), 1);
            if (iv && in_ready_v[s]) begin
                exp_en = 16'h8000;
                exp_en = exp_en >> (4 * (words % 4));
                check("buf_en_word", int'(buf_en_v[s]), int'(exp_en));
                words++;
            end else if (buf_en_v[s] != 16'h0) begin
                spurious++;
            end
            if (buf_shift_v[s]) begin
                shifts++;
                if (buf_en_v[s] != 16'h0) clash++;
            end
            if (win_valid_v[s] && !orr) begin
                stall_obs++;
                if (sb.size() > 0) check("stall_hold_idx", int'(ridx_v[s]), sb[0].idx);
            end
            if (win_valid_v[s] && orr) begin
                check("window_pending", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    pops++;
                    check("window_idx", int'(prev_ridx), e.idx);
                    check("win_last_col", int'(wlc_v[s]), int'(e.lc));
                    check("win_last_row", int'(wlr_v[s]), int'(e.lr));
                    if (e.lc && e.lr) ending = 1'b1;
                end
            end
            prev_stall = win_valid_v[s] && !orr;
            prev_ridx = ridx_v[s];
            cyc++;
            if (abort_pops > 0 && pops >= abort_pops) return;
            if (!ending) @(negedge clk);
        end
        check("frame_done", int'(ending), 1);
        @(negedge clk);
        start_v[s] = 1'b0;
        in_valid_v[s] = 1'b0;
        out_ready_v[s] = 1'b1;
        #1;
        check("busy_drop", int'(busy_v[s]), 0);
        check("words", words, v.exp_words);
        check("shifts", shifts, v.exp_shifts);
        check("windows", pops, v.exp_wins);
        check("sb_empty", sb.size(), 0);
        check("buf_en_idle_zero", spurious, 0);
        check("shift_en_clash", clash, 0);
        check("stall_cycles", stall_obs, v.stall_len);
`ifdef CONV_BUF_SEQ_PERF_EN
        if (v.gap != 1) check("stall_in_cnt", int'(sic_v[s]), v.ingaps);
        check("stall_out_cnt", int'(soc_v[s]), v.stall_len);
`endif
        sb.delete();
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{0, 0, 0, -1, 0, 1'b0, 16, 3, 13};
        vecs[1] = '{1, 0, 0, -1, 0, 1'b0, 24, 5, 12};
        vecs[2] = '{1, 0, 0,  4, 5, 1'b0, 24, 5, 12};
        vecs[3] = '{0, 1, 0, -1, 0, 1'b0, 16, 3, 13};
        vecs[4] = '{1, 2, 3,  8, 2, 1'b1, 24, 5, 12};

        rst_n = 1'b0;
        start_v = '0;
        in_valid_v = '0;
        out_ready_v = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_reset(0);
        check_reset(1);

        for (int i = 0; i < 5; i++) run_frame(vecs[i], 0);

        // Abort the 6-row frame in its second band, then rerun it.
        run_frame(vecs[1], 5);
        check("pre_reset_busy", int'(busy_v[1]), 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset(1);
        sb.delete();
        start_v[1] = 1'b0;
        in_valid_v[1] = 1'b0;
        out_ready_v[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(vecs[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
